bp_me_cache_pkt_arbiter: RTL and testbench

BP_ME_CACHE_PKT_ARBITER -- requirements
Module: bp_me_cache_pkt_arbiter

---
 rtl/bp_me_cache_pkt_arbiter.sv | 122 ++++++++++++
 tb/tb_bp_me_cache_pkt_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bp_me_cache_pkt_arbiter.sv
// Two-requester arbiter in front of a bsg_cache, with a tag FIFO that routes in-order responses back.
// Define BP_ME_CACHE_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module bp_me_cache_pkt_arbiter #(
  parameter int unsigned pkt_width_p  = 128,
  parameter int unsigned data_width_p = 64,
  parameter int unsigned tag_els_p    = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,

  input  logic [1:0][pkt_width_p-1:0]  req_pkt_i,
  input  logic [1:0]                   req_v_i,
  output logic [1:0]                   req_yumi_o,

  output logic [pkt_width_p-1:0]       cache_pkt_o,
  output logic                         cache_pkt_v_o,
  input  logic                         cache_pkt_ready_i,

  input  logic [data_width_p-1:0]      cache_data_i,
  input  logic                         cache_v_i,
  output logic                         cache_yumi_o,

  output logic [data_width_p-1:0]      resp_data_o,
  output logic [1:0]                   resp_v_o,
  input  logic [1:0]                   resp_yumi_i,

  output logic                         err_unexpected_resp_o
);

  localparam int unsigned ptr_w_lp = (tag_els_p > 1) ? $clog2(tag_els_p) : 1;
  localparam int unsigned cnt_w_lp = ptr_w_lp + 1;
  localparam logic [ptr_w_lp-1:0] ptr_max_lp  = ptr_w_lp'(tag_els_p - 1);
  localparam logic [cnt_w_lp-1:0] cnt_full_lp = cnt_w_lp'(tag_els_p);

  logic [tag_els_p-1:0] tags_q, tags_d;
  logic [ptr_w_lp-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ptr_w_lp-1:0]  rd_ptr_q, rd_ptr_d;
  logic [cnt_w_lp-1:0]  cnt_q, cnt_d;
  logic                 err_q, err_d;
`ifndef BP_ME_CACHE_ARB_FIXED_PRIO_EN
  logic                 last_q, last_d;
`endif

  logic full, empty, grant, winner, head, resp_v, push, pop;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_max_lp) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    full  = (cnt_q == cnt_full_lp);
    empty = (cnt_q == '0);
    grant = ~reset_i & cache_pkt_ready_i & ~full & (|req_v_i);

`ifdef BP_ME_CACHE_ARB_FIXED_PRIO_EN
    winner = ~req_v_i[0];
`else
    // On contention the requester that did not win last time goes next.
    winner = (&req_v_i) ? ~last_q : req_v_i[1];
`endif

    req_yumi_o         = '0;
    req_yumi_o[winner] = grant;
    cache_pkt_v_o      = grant;
    cache_pkt_o        = req_pkt_i[winner];

    head             = tags_q[rd_ptr_q];
    resp_v           = ~reset_i & cache_v_i & ~empty;
    resp_v_o         = '0;
    resp_v_o[head]   = resp_v;
    cache_yumi_o     = resp_v & resp_yumi_i[head];
    resp_data_o      = cache_data_i;

    err_unexpected_resp_o = err_q;
  end

  always_comb begin
    push = grant;
    pop  = cache_yumi_o;

    tags_d = tags_q;
    if (push) tags_d[wr_ptr_q] = winner;

    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    err_d = err_q | (cache_v_i & empty);
`ifndef BP_ME_CACHE_ARB_FIXED_PRIO_EN
    last_d = push ? winner : last_q;
`endif
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tags_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
`ifndef BP_ME_CACHE_ARB_FIXED_PRIO_EN
      last_q   <= 1'b1;
`endif
    end else begin
      tags_q   <= tags_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`ifndef BP_ME_CACHE_ARB_FIXED_PRIO_EN
      last_q   <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_bp_me_cache_pkt_arbiter.sv
// Bench for bp_me_cache_pkt_arbiter: queue-based model checked every cycle, plus directed scenarios.
module tb_bp_me_cache_pkt_arbiter;

  logic              clk_i = 1'b0;
  logic              reset_i = 1'b1;
  logic [1:0][127:0] req_pkt_i = '0;
  logic [1:0]        req_v_i = '0;
  logic [1:0]        req_yumi_o;
  logic [127:0]      cache_pkt_o;
  logic              cache_pkt_v_o;
  logic              cache_pkt_ready_i = 1'b0;
  logic [63:0]       cache_data_i = '0;
  logic              cache_v_i = 1'b0;
  logic              cache_yumi_o;
  logic [63:0]       resp_data_o;
  logic [1:0]        resp_v_o;
  logic [1:0]        resp_yumi_i = '0;
  logic              err_unexpected_resp_o;

  bp_me_cache_pkt_arbiter #(.pkt_width_p(128), .data_width_p(64), .tag_els_p(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_pkt_i(req_pkt_i), .req_v_i(req_v_i), .req_yumi_o(req_yumi_o),
    .cache_pkt_o(cache_pkt_o), .cache_pkt_v_o(cache_pkt_v_o), .cache_pkt_ready_i(cache_pkt_ready_i),
    .cache_data_i(cache_data_i), .cache_v_i(cache_v_i), .cache_yumi_o(cache_yumi_o),
    .resp_data_o(resp_data_o), .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i),
    .err_unexpected_resp_o(err_unexpected_resp_o)
  );

  always #5 clk_i = ~clk_i;

  // Model: outstanding tags in grant order, last winner, sticky error.
  bit mq[$];
  bit mlast = 1'b1;
  bit merr  = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [1:0] obs_yumi, obs_rv;
  logic       obs_pkt_v, obs_cyumi, obs_err;
  logic [63:0] obs_data;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit [1:0] v, input bit rdy, input bit cv,
                      input bit [1:0] ry, input logic [63:0] data);
    bit       gnt, win, head, cyumi, was_empty;
    bit [1:0] exp_yumi, exp_rv;
    @(negedge clk_i);
    reset_i           = rst;
    req_v_i           = v;
    cache_pkt_ready_i = rdy;
    cache_v_i         = cv;
    resp_yumi_i       = ry;
    cache_data_i      = data;
    for (int i = 0; i < 2; i++)
      req_pkt_i[i] = {$urandom, $urandom, $urandom, $urandom};
    if (rst) begin
      mq.delete();
      mlast = 1'b1;
      merr  = 1'b0;
    end
    #1;
    was_empty = (mq.size() == 0);
    gnt = !rst && rdy && (mq.size() < 4) && (v != 2'b00);
`ifdef BP_ME_CACHE_ARB_FIXED_PRIO_EN
    win = v[0] ? 1'b0 : 1'b1;
`else
    win = (v == 2'b11) ? !mlast : v[1];
`endif
    exp_yumi = gnt ? (2'b01 << win) : 2'b00;
    head     = was_empty ? 1'b0 : mq[0];
    exp_rv   = (!rst && cv && !was_empty) ? (2'b01 << head) : 2'b00;
    cyumi    = (exp_rv != 2'b00) && ry[head];

    chk("pkt_v", cache_pkt_v_o, gnt);
    chk("req_yumi", req_yumi_o, exp_yumi);
    if (gnt) chk("cache_pkt", cache_pkt_o, req_pkt_i[win]);
    chk("resp_v", resp_v_o, exp_rv);
    chk("cache_yumi", cache_yumi_o, cyumi);
    chk("resp_data", resp_data_o, data);
    chk("err", err_unexpected_resp_o, merr);

    obs_yumi = req_yumi_o; obs_rv = resp_v_o; obs_pkt_v = cache_pkt_v_o;
    obs_cyumi = cache_yumi_o; obs_err = err_unexpected_resp_o; obs_data = resp_data_o;

    @(posedge clk_i);
    if (!rst) begin
      if (cyumi) void'(mq.pop_front());
      if (gnt) begin
        mq.push_back(win);
        mlast = win;
      end
      if (cv && was_empty) merr = 1'b1;
    end
  endtask

  initial begin
    // Reset state
    step(1, 2'b11, 1, 1, 2'b11, 64'h1);
    chk("rst_pkt_v", obs_pkt_v, 1'b0);
    chk("rst_yumi", obs_yumi, 2'b00);
    chk("rst_resp_v", obs_rv, 2'b00);
    chk("rst_err", obs_err, 1'b0);

    // Post-reset contention fills the FIFO
`ifdef BP_ME_CACHE_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) begin
      step(0, 2'b11, 1, 0, 2'b00, 64'h0);
      chk("fixed_grant", obs_yumi, 2'b01);
    end
`else
    step(0, 2'b11, 1, 0, 2'b00, 64'h0); chk("rr_g0", obs_yumi, 2'b01);
    step(0, 2'b11, 1, 0, 2'b00, 64'h0); chk("rr_g1", obs_yumi, 2'b10);
    step(0, 2'b11, 1, 0, 2'b00, 64'h0); chk("rr_g2", obs_yumi, 2'b01);
    step(0, 2'b11, 1, 0, 2'b00, 64'h0); chk("rr_g3", obs_yumi, 2'b10);
`endif
    step(0, 2'b11, 1, 0, 2'b00, 64'h0); chk("full_block", obs_pkt_v, 1'b0);

    // Full plus pop: grant only on the following cycle
    step(0, 2'b01, 1, 1, 2'b11, 64'h5);
    chk("fp_nogrant", obs_pkt_v, 1'b0);
    chk("fp_pop", obs_cyumi, 1'b1);
    step(0, 2'b01, 1, 0, 2'b00, 64'h0);
    chk("fp_grant", obs_yumi, 2'b01);
    step(0, 2'b01, 1, 0, 2'b00, 64'h0);
    chk("fp_full_again", obs_pkt_v, 1'b0);
    for (int i = 0; i < 4; i++) step(0, 2'b00, 1, 1, 2'b11, 64'(i));

    // Ordered return: grants 1,0,0
    step(0, 2'b10, 1, 0, 2'b00, 64'h0); chk("ord_g0", obs_yumi, 2'b10);
    step(0, 2'b01, 1, 0, 2'b00, 64'h0); chk("ord_g1", obs_yumi, 2'b01);
    step(0, 2'b01, 1, 0, 2'b00, 64'h0); chk("ord_g2", obs_yumi, 2'b01);
    step(0, 2'b00, 1, 1, 2'b11, 64'hA); chk("ord_r0", obs_rv, 2'b10); chk("ord_d0", obs_data, 64'hA);
    step(0, 2'b00, 1, 1, 2'b11, 64'hB); chk("ord_r1", obs_rv, 2'b01); chk("ord_d1", obs_data, 64'hB);
    step(0, 2'b00, 1, 1, 2'b11, 64'hC); chk("ord_r2", obs_rv, 2'b01); chk("ord_d2", obs_data, 64'hC);

    // Backpressure holds the head
    step(0, 2'b10, 1, 0, 2'b00, 64'h0);
    for (int i = 0; i < 3; i++) begin
      step(0, 2'b00, 1, 1, 2'b00, 64'h77);
      chk("bp_cyumi", obs_cyumi, 1'b0);
      chk("bp_head", obs_rv, 2'b10);
    end
    step(0, 2'b00, 1, 1, 2'b10, 64'h77); chk("bp_release", obs_cyumi, 1'b1);

    // Spurious response sets the sticky error; reset clears everything
    step(0, 2'b00, 1, 1, 2'b11, 64'h9);
    chk("sp_rv", obs_rv, 2'b00);
    chk("sp_cyumi", obs_cyumi, 1'b0);
    step(0, 2'b00, 1, 0, 2'b00, 64'h0); chk("sp_err0", obs_err, 1'b1);
    step(0, 2'b11, 1, 0, 2'b00, 64'h0); chk("sp_err1", obs_err, 1'b1);
    step(1, 2'b11, 1, 1, 2'b11, 64'h3);
    chk("rp_pkt_v", obs_pkt_v, 1'b0);
    chk("rp_yumi", obs_yumi, 2'b00);
    chk("rp_rv", obs_rv, 2'b00);
    chk("rp_cyumi", obs_cyumi, 1'b0);
    chk("rp_err", obs_err, 1'b0);

    // Random traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 299) == 0, 2'($urandom), $urandom_range(0, 9) < 7,
           $urandom_range(0, 2) != 0, 2'($urandom), {$urandom, $urandom});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
